csr_axil_master: RTL and testbench

- AXI4-Lite initiator that drives the accelerator CSR slave (s00_axi_*). Used by the on-chip test sequencer and the layer-scheduler to program layer registers and poll status.
- Converts a simple single-outstanding request/response interface into AXI4-Lite write (AW+W→B) or read (AR→R) transactions.
- Sits between the scheduler and the accelerator's s00_axi port, on the same clk domain.

---
 rtl/csr_axil_pkg.sv | 26 ++
 rtl/csr_axil_master.sv | 183 ++++++++++++++++++
 tb/tb_csr_axil_master.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_axil_pkg.sv
// Shared types and constants for the CSR AXI4-Lite initiator.
package csr_axil_pkg;

   // Bus widths shared with the accelerator CSR slave.
   localparam int unsigned CSR_ADDR_WIDTH = 32;
   localparam int unsigned CSR_DATA_WIDTH = 32;

   // AXI response codes.
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Unprivileged, secure, data access.
   localparam logic [2:0] PROT_DEFAULT = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WADDR_DATA,
      ST_WRESP,
      ST_RADDR,
      ST_RDATA,
      ST_RSP
   } state_t;

endpackage

// File: rtl/csr_axil_master.sv
// Single-outstanding request/response to AXI4-Lite initiator.
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where valid and ready are both high; once valid is raised it stays high,
// with its payload unchanged, until that edge.
module csr_axil_master
   import csr_axil_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = CSR_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = CSR_DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      rsp_write,
   output logic                      timeout,
   output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [2:0]                m_axi_awprot,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic [2:0]                m_axi_arprot,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready
);

   localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

   state_t                    state;
   state_t                    state_next;

   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [DATA_WIDTH/8-1:0]   wstrb_q;
   logic                      write_q;
   logic                      aw_done;
   logic                      w_done;
   logic [DATA_WIDTH-1:0]     rdata_q;
   logic [1:0]                resp_q;
   logic [31:0]               tcount;
   logic [31:0]               tcount_inc;
   logic                      timeout_q;
   logic                      accept;
   logic                      counting;

   assign accept     = (state == ST_IDLE) && req_valid;
   assign counting   = (state != ST_IDLE) && (state != ST_RSP);
   assign tcount_inc = (tcount == 32'hFFFF_FFFF) ? tcount : tcount + 32'd1;

   // AXI payloads come only from the latched request, never from req_*.
   assign m_axi_awaddr = addr_q;
   assign m_axi_araddr = addr_q;
   assign m_axi_wdata  = wdata_q;
   assign m_axi_wstrb  = wstrb_q;
   assign m_axi_awprot = PROT_DEFAULT;
   assign m_axi_arprot = PROT_DEFAULT;
   assign rsp_rdata    = rdata_q;
   assign rsp_resp     = resp_q;
   assign rsp_write    = write_q;
   assign timeout      = timeout_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next-state decode and per-state handshake outputs.
   always_comb begin
      state_next    = state;
      req_ready     = 1'b0;
      rsp_valid     = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = req_write ? ST_WADDR_DATA : ST_RADDR;
         end
         ST_WADDR_DATA: begin
            // AW and W retire independently; leave once both have transferred.
            m_axi_awvalid = !aw_done;
            m_axi_wvalid  = !w_done;
            if ((aw_done || m_axi_awready) && (w_done || m_axi_wready))
               state_next = ST_WRESP;
         end
         ST_WRESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) state_next = ST_RSP;
         end
         ST_RADDR: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) state_next = ST_RDATA;
         end
         ST_RDATA: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid) state_next = ST_RSP;
         end
         ST_RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Request latch, per-channel done flags and response capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         write_q <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         rdata_q <= '0;
         resp_q  <= '0;
      end else begin
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            write_q <= req_write;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
         end
         if (state == ST_WADDR_DATA) begin
            if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
            if (m_axi_wvalid && m_axi_wready)   w_done  <= 1'b1;
         end
         if (state == ST_WRESP && m_axi_bvalid) begin
            resp_q  <= m_axi_bresp;
            rdata_q <= '0;
         end
         if (state == ST_RDATA && m_axi_rvalid) begin
            resp_q  <= m_axi_rresp;
            rdata_q <= m_axi_rdata;
         end
      end
   end

   // Saturating bus-wait counter with a sticky flag; it only reports, the
   // transaction keeps running so the AXI channels stay legal.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcount    <= '0;
         timeout_q <= 1'b0;
      end else if (accept) begin
         tcount    <= '0;
         timeout_q <= 1'b0;
      end else if (counting) begin
         tcount <= tcount_inc;
         if (TIMEOUT_LIMIT != 32'd0 && tcount_inc == TIMEOUT_LIMIT)
            timeout_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_csr_axil_master.sv
// Randomized bench for csr_axil_master against a behavioural AXI-Lite slave
// and a word-array reference model.
module tb_csr_axil_master;
   import csr_axil_pkg::*;

   localparam int TO = 16;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk;
   logic            rst;
   logic            req_valid;
   logic            req_ready;
   logic            req_write;
   logic [AW-1:0]   req_addr;
   logic [DW-1:0]   req_wdata;
   logic [DW/8-1:0] req_wstrb;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [DW-1:0]   rsp_rdata;
   logic [1:0]      rsp_resp;
   logic            rsp_write;
   logic            timeout;
   logic [AW-1:0]   m_axi_awaddr;
   logic [2:0]      m_axi_awprot;
   logic            m_axi_awvalid;
   logic            m_axi_awready;
   logic [DW-1:0]   m_axi_wdata;
   logic [DW/8-1:0] m_axi_wstrb;
   logic            m_axi_wvalid;
   logic            m_axi_wready;
   logic [1:0]      m_axi_bresp;
   logic            m_axi_bvalid;
   logic            m_axi_bready;
   logic [AW-1:0]   m_axi_araddr;
   logic [2:0]      m_axi_arprot;
   logic            m_axi_arvalid;
   logic            m_axi_arready;
   logic [DW-1:0]   m_axi_rdata;
   logic [1:0]      m_axi_rresp;
   logic            m_axi_rvalid;
   logic            m_axi_rready;

   csr_axil_master #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_write(rsp_write), .timeout(timeout),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard counters / check ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_word(input int i);
      if (i == 11) return 32'h0000_0001;
      return (32'(i) * 32'h0101_0101) ^ 32'h5A00_0000;
   endfunction

   // Sticky flag expected after n cycles spent on the bus since accept.
   function automatic logic exp_timeout(input int k);
      return (TO != 0) && (k - 1 >= TO);
   endfunction

   // ---------------- slave configuration (written by driver) ----------------
   int         aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   logic [1:0] b_resp_cfg = RESP_OKAY;
   logic [1:0] r_resp_cfg = RESP_OKAY;
   int         txn_seq = 0;

   // ---------------- behavioural AXI-Lite slave ----------------
   logic [31:0] slv_mem [16];
   int          s_seq;
   int          aw_n, w_n, ar_n;
   int          aw_hs_edge, w_hs_edge, ar_hs_edge;
   logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
   logic [3:0]  cap_wstrb;
   int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
   bit          wr_applied, b_pend, r_pend, p_bhs, p_rhs;
   bit          p_aw, p_w, p_ar;
   logic [31:0] p_awaddr, p_wdata, p_araddr;
   logic [3:0]  p_wstrb;

   task automatic slave_clear();
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_bresp = 0;
      m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 32'hDEAD_BEEF;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      b_pend = 0; r_pend = 0; p_bhs = 0; p_rhs = 0;
      p_aw = 0; p_w = 0; p_ar = 0;
   endtask

   initial begin : slave
      for (int i = 0; i < 16; i++) slv_mem[i] = init_word(i);
      s_seq = 0; aw_n = 0; w_n = 0; ar_n = 0; wr_applied = 0;
      aw_hs_edge = 0; w_hs_edge = 0; ar_hs_edge = 0;
      cap_awaddr = 0; cap_wdata = 0; cap_araddr = 0; cap_wstrb = 0;
      p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
      slave_clear();
      forever begin
         @(negedge clk);
         if (s_seq != txn_seq) begin
            s_seq = txn_seq; aw_n = 0; w_n = 0; ar_n = 0; wr_applied = 0;
         end
         if (rst) begin
            slave_clear();
         end else begin
            // valids left pending at the last edge must still be up, unchanged
            if (p_aw) begin
               check_eq("awvalid_held", m_axi_awvalid, 1);
               check_eq("awaddr_held", m_axi_awaddr, p_awaddr);
            end
            if (p_w) begin
               check_eq("wvalid_held", m_axi_wvalid, 1);
               check_eq("wdata_held", m_axi_wdata, p_wdata);
               check_eq("wstrb_held", m_axi_wstrb, p_wstrb);
            end
            if (p_ar) begin
               check_eq("arvalid_held", m_axi_arvalid, 1);
               check_eq("araddr_held", m_axi_araddr, p_araddr);
            end
            if (m_axi_bready) check_eq("bready_after_aw_w", (aw_n > 0 && w_n > 0), 1);
            // B channel
            if (m_axi_bvalid && p_bhs) begin
               m_axi_bvalid = 0; b_pend = 0;
            end else if (b_pend && !m_axi_bvalid) begin
               if (b_wait >= b_delay) begin m_axi_bvalid = 1; m_axi_bresp = b_resp_cfg; end
               else b_wait++;
            end
            p_bhs = m_axi_bvalid && m_axi_bready;
            // R channel
            if (m_axi_rvalid && p_rhs) begin
               m_axi_rvalid = 0; r_pend = 0; m_axi_rdata = 32'hDEAD_BEEF;
            end else if (r_pend && !m_axi_rvalid) begin
               if (r_wait >= r_delay) begin
                  m_axi_rvalid = 1; m_axi_rresp = r_resp_cfg;
                  m_axi_rdata  = slv_mem[cap_araddr[5:2]];
               end else r_wait++;
            end
            p_rhs = m_axi_rvalid && m_axi_rready;
            // AW channel
            m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
            if (m_axi_awvalid && !m_axi_awready) aw_wait++;
            if (m_axi_awvalid && m_axi_awready) begin
               aw_n++; cap_awaddr = m_axi_awaddr; aw_hs_edge = cyc + 1; aw_wait = 0;
            end
            p_aw = m_axi_awvalid && !m_axi_awready; p_awaddr = m_axi_awaddr;
            // W channel
            m_axi_wready = m_axi_wvalid && (w_wait >= w_delay);
            if (m_axi_wvalid && !m_axi_wready) w_wait++;
            if (m_axi_wvalid && m_axi_wready) begin
               w_n++; cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb;
               w_hs_edge = cyc + 1; w_wait = 0;
            end
            p_w = m_axi_wvalid && !m_axi_wready; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
            if (aw_n > 0 && w_n > 0 && !wr_applied) begin
               for (int b = 0; b < 4; b++)
                  if (cap_wstrb[b]) slv_mem[cap_awaddr[5:2]][8*b +: 8] = cap_wdata[8*b +: 8];
               wr_applied = 1; b_pend = 1; b_wait = 0;
            end
            // AR channel
            m_axi_arready = m_axi_arvalid && (ar_wait >= ar_delay);
            if (m_axi_arvalid && !m_axi_arready) ar_wait++;
            if (m_axi_arvalid && m_axi_arready) begin
               ar_n++; cap_araddr = m_axi_araddr; ar_hs_edge = cyc + 1; ar_wait = 0;
               r_pend = 1; r_wait = 0;
            end
            p_ar = m_axi_arvalid && !m_axi_arready; p_araddr = m_axi_araddr;
         end
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [16];

   // ---------------- driver ----------------
   // Called and returns on a falling edge.
   task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int hold, input int exp_lat);
      int          k;
      int          lat;
      int          acc_edge;
      bit          ok;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      logic [31:0] w;
      txn_seq++;
      req_valid = 1; req_write = wr; req_addr = addr; req_wdata = data; req_wstrb = strb;
      ok = 0; acc_edge = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (req_ready) begin ok = 1; acc_edge = cyc + 1; end
         else @(negedge clk);
      end
      check_eq("req_accepted", ok, 1);
      @(negedge clk);
      req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
      if (!ok) return;
      // expected outcome from the request alone
      if (wr) begin
         w = ref_mem[addr[5:2]];
         for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
         ref_mem[addr[5:2]] = w;
         exp_rdata = 32'h0;
         exp_resp  = b_resp_cfg;
      end else begin
         exp_rdata = ref_mem[addr[5:2]];
         exp_resp  = r_resp_cfg;
      end
      k = 1;
      while (!rsp_valid && k < 200) begin
         check_eq("req_ready_busy", req_ready, 0);
         check_eq("timeout_busy", timeout, exp_timeout(k));
         @(negedge clk);
         k++;
      end
      check_eq("rsp_arrived", rsp_valid, 1);
      lat = k;
      if (exp_lat > 0) check_eq("latency", lat, exp_lat);
      if (wr) begin
         check_eq("aw_count", aw_n, 1);
         check_eq("w_count", w_n, 1);
         check_eq("ar_none", ar_n, 0);
         check_eq("awaddr", cap_awaddr, addr);
         check_eq("wdata", cap_wdata, data);
         check_eq("wstrb", cap_wstrb, strb);
         check_eq("awprot", m_axi_awprot, PROT_DEFAULT);
         if (exp_lat == 3) begin
            check_eq("aw_edge", aw_hs_edge - acc_edge, 1);
            check_eq("w_edge", w_hs_edge - acc_edge, 1);
         end
      end else begin
         check_eq("ar_count", ar_n, 1);
         check_eq("aw_none", aw_n + w_n, 0);
         check_eq("araddr", cap_araddr, addr);
         check_eq("arprot", m_axi_arprot, PROT_DEFAULT);
         if (exp_lat == 3) check_eq("ar_edge", ar_hs_edge - acc_edge, 1);
      end
      for (int j = 0; j <= hold; j++) begin
         if (j > 0) @(negedge clk);
         check_eq("rsp_valid_hold", rsp_valid, 1);
         check_eq("rsp_write", rsp_write, wr);
         check_eq("rsp_resp", rsp_resp, exp_resp);
         check_eq("rsp_rdata", rsp_rdata, exp_rdata);
         check_eq("req_ready_rsp", req_ready, 0);
         check_eq("timeout_rsp", timeout, exp_timeout(lat));
      end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      check_eq("rsp_valid_done", rsp_valid, 0);
      check_eq("req_ready_idle", req_ready, 1);
      check_eq("timeout_idle", timeout, exp_timeout(lat));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
      rsp_ready = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      repeat (3) @(negedge clk);
      check_eq("rst_req_ready", req_ready, 1);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_timeout", timeout, 0);
      check_eq("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
      check_eq("rst_readies", {m_axi_bready, m_axi_rready}, 0);
      check_eq("rst_awaddr", m_axi_awaddr, 0);
      check_eq("rst_wdata", m_axi_wdata, 0);
      check_eq("rst_rsp_rdata", rsp_rdata, 0);
      check_eq("rst_rsp_resp", rsp_resp, 0);
      @(posedge clk); #2 rst = 0;
      @(negedge clk);

      // minimum-latency write and read
      run_txn(1, 32'h08, 32'h0000_0010, 4'hF, 0, 3);
      run_txn(0, 32'h08, 32'h0, 4'h0, 0, 3);
      // read with slow arready and delayed rvalid
      ar_delay = 2; r_delay = 3;
      run_txn(0, 32'h2C, 32'h0, 4'h0, 0, 8);
      ar_delay = 0; r_delay = 0;
      // W lags AW by 4 cycles
      w_delay = 4;
      run_txn(1, 32'h14, 32'hCAFE_F00D, 4'hF, 0, 7);
      w_delay = 0;
      // W completes 2 cycles before AW
      aw_delay = 2;
      run_txn(1, 32'h18, 32'h1234_5678, 4'h5, 0, 5);
      aw_delay = 0;
      // SLVERR read, response back-pressured for 5 cycles
      r_resp_cfg = RESP_SLVERR;
      run_txn(0, 32'h2C, 32'h0, 4'h0, 5, 3);
      r_resp_cfg = RESP_OKAY;
      // timeout while B is withheld, then cleared by the next accept
      b_delay = 40; b_resp_cfg = RESP_DECERR;
      run_txn(1, 32'h30, 32'hAABB_CCDD, 4'h3, 1, 43);
      b_delay = 0; b_resp_cfg = RESP_OKAY;
      run_txn(0, 32'h30, 32'h0, 4'h0, 0, 3);

      // reset in the middle of the write address/data phase
      txn_seq++;
      aw_delay = 50; w_delay = 50;
      req_valid = 1; req_write = 1; req_addr = 32'h10; req_wdata = 32'hA5A5_0001; req_wstrb = 4'hF;
      check_eq("rstmid_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 0;
      @(negedge clk);
      check_eq("rstmid_awvalid_pre", m_axi_awvalid, 1);
      check_eq("rstmid_wvalid_pre", m_axi_wvalid, 1);
      #2 rst = 1;
      #1;
      check_eq("rstmid_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 0);
      check_eq("rstmid_readies", {m_axi_bready, m_axi_rready}, 0);
      check_eq("rstmid_awaddr", m_axi_awaddr, 0);
      check_eq("rstmid_req_ready", req_ready, 1);
      repeat (2) @(posedge clk);
      #2 rst = 0;
      aw_delay = 0; w_delay = 0;
      @(negedge clk);
      check_eq("rstmid_idle", req_ready, 1);

      // randomized traffic
      for (int n = 0; n < 30; n++) begin
         aw_delay   = $urandom_range(0, 3);
         w_delay    = $urandom_range(0, 3);
         b_delay    = $urandom_range(0, 3);
         ar_delay   = $urandom_range(0, 3);
         r_delay    = $urandom_range(0, 3);
         b_resp_cfg = 2'($urandom_range(0, 3));
         r_resp_cfg = 2'($urandom_range(0, 3));
         run_txn(1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                 $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
